// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
//   - uart_state_e : receiver FSM states
//   - frame constants: default data width, default clocks per bit, line levels
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_e;

   // 50 MHz system clock at 115200 baud
   localparam int unsigned UART_CLKS_PER_BIT_DEF = 434;
   localparam int unsigned UART_WIDTH_DEF        = 8;

   // Line idles high; a good frame ends with a high stop bit
   localparam logic UART_IDLE_LEVEL = 1'b1;
   localparam logic UART_STOP_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin.
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset, both flops load RST_VAL
//   d_i     : asynchronous input
//   q_o     : synchronized output (two clk_i cycles of latency)
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver, 8N1-style framing, LSB first, oversampled on CLOCK.
//   CLOCK      : system clock, rising edge
//   RESET_N    : asynchronous active-low reset
//   rx         : serial line, idle high, asynchronous to CLOCK
//   data_out   : last correctly framed word, held until the next good frame
//   data_valid : one-cycle strobe, data_out valid in the same cycle
//   frame_err  : one-cycle strobe, stop bit sampled low
//   busy       : high whenever the receiver is not idle
//
// state | meaning
// IDLE  | waiting for rx_s low (start edge)
// START | counting to the start-bit center, re-checking the line there
// DATA  | sampling WIDTH data bits at their centers
// STOP  | sampling the stop bit at its center
// BREAK | stop bit was low, waiting for the line to return high
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH        = UART_WIDTH_DEF,
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
   input  logic             CLOCK,
   input  logic             RESET_N,
   input  logic             rx,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_err,
   output logic             busy
);

   localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [15:0]      HALF_TC  = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0]      BIT_TC   = 16'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   logic             rx_s;

   uart_state_e      state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;

   sync_2ff #(
      .RST_VAL (UART_IDLE_LEVEL)
   ) u_rx_sync (
      .clk_i   (CLOCK),
      .rst_n_i (RESET_N),
      .d_i     (rx),
      .q_o     (rx_s)
   );

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end

         START: begin
            if (cnt_q == HALF_TC) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  // line went back high before mid start bit: treat as noise
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         DATA: begin
            if (cnt_q == BIT_TC) begin
               cnt_d = '0;
               // shift right with the new bit entering at the MSB, so the
               // first (LSB) bit lands in bit 0; no [WIDTH-1:1] slice so
               // WIDTH = 1 still elaborates
               sh_d = WIDTH'({rx_s, sh_q} >> 1);
               if (idx_q == LAST_IDX) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         STOP: begin
            if (cnt_q == BIT_TC) begin
               cnt_d = '0;
               if (rx_s == UART_STOP_LEVEL) begin
                  data_d  = sh_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         BREAK: begin
            // a held-low line reports once, then stays here until released
            cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core with CLKS_PER_BIT = 16.
// The serial line is driven in absolute time so bit periods can be skewed
// independently of the receiver clock; received bytes are collected by a
// monitor and compared against the byte stream the bench intended to send.
module tb_uart_rx_core;

   localparam int WIDTH    = 8;
   localparam int CPB      = 16;
   localparam int HALF_CLK = 5000;
   localparam int BIT_NOM  = CPB * 2 * HALF_CLK;       // 160000
   localparam int BIT_FAST = (BIT_NOM * 98) / 100;     // -2 % period
   localparam int BIT_SLOW = (BIT_NOM * 102) / 100;    // +2 % period

   logic             CLOCK   = 1'b0;
   logic             RESET_N = 1'b0;
   logic             rx      = 1'b1;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             frame_err;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [WIDTH-1:0] got_q[$];
   int               got_cyc_q[$];
   int               fe_cnt   = 0;
   logic             prev_dv  = 1'b0;
   logic [WIDTH-1:0] last_good = '0;

   uart_rx_core #(
      .WIDTH        (WIDTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .CLOCK      (CLOCK),
      .RESET_N    (RESET_N),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #(HALF_CLK) CLOCK = ~CLOCK;

   always @(posedge CLOCK) cyc++;

   // pulse monitor, sampled mid-cycle
   always @(negedge CLOCK) begin
      if (data_valid) begin
         got_q.push_back(data_out);
         got_cyc_q.push_back(cyc);
         n_cmp++;
         if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_on_valid: busy=%b with data_valid, required 0", busy);
         end
         n_cmp++;
         if (prev_dv) begin
            n_bad++;
            $display("FAIL valid_width: data_valid high 2 cycles, required 1-cycle pulse");
         end
      end
      if (frame_err) fe_cnt++;
      if (data_valid || frame_err) begin
         n_cmp++;
         if (data_valid && frame_err) begin
            n_bad++;
            $display("FAIL pulse_excl: data_valid=%b frame_err=%b, required never both",
                     data_valid, frame_err);
         end
      end
      prev_dv = data_valid;
   end

   task automatic clear_obs();
      got_q.delete();
      got_cyc_q.delete();
      fe_cnt = 0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge CLOCK);
   endtask

   // drive one frame; rx is left at the stop level afterwards
   task automatic send_frame(input logic [7:0] b, input int bit_t, input int stop_t,
                             input logic stop_lvl, input bit align, output int t0);
      if (align) begin
         @(posedge CLOCK);
         #1;
      end
      t0 = cyc;
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_t);
      end
      rx = stop_lvl;
      #(stop_t);
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLOCK);
         #1 rx = 1'($urandom_range(0, 1));
         @(negedge CLOCK);
         n_cmp++;
         if ({data_out, data_valid, frame_err, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: data_out=%02h dv=%b fe=%b busy=%b, required all 0",
                     data_out, data_valid, frame_err, busy);
         end
      end
      rx = 1'b1;
      wait_cycles(3);
      #1 RESET_N = 1'b1;
      clear_obs();
      wait_cycles(20 * CPB);
      @(negedge CLOCK);
      n_cmp++;
      if (got_q.size() != 0 || fe_cnt != 0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: valids=%0d frame_errs=%0d busy=%b, required 0/0/0",
                  got_q.size(), fe_cnt, busy);
      end
   endtask

   task automatic test_single();
      int t0, t1;
      clear_obs();
      send_frame(8'hA8, BIT_NOM, BIT_NOM, 1'b1, 1'b1, t0);
      send_frame(8'hA9, BIT_NOM, BIT_NOM, 1'b1, 1'b0, t1);
      wait_cycles(4);
      @(negedge CLOCK);
      n_cmp++;
      if (got_q.size() != 2) begin
         n_bad++;
         $display("FAIL single_count: got %0d valids, required 2", got_q.size());
      end else begin
         n_cmp++;
         if (got_q[0] !== 8'hA8) begin
            n_bad++;
            $display("FAIL single_byte0: got %02h, required a8", got_q[0]);
         end
         n_cmp++;
         if (got_q[1] !== 8'hA9) begin
            n_bad++;
            $display("FAIL single_byte1: got %02h, required a9", got_q[1]);
         end
         // 3 cycles sync + detect, half bit, 9 full bits to the stop center
         n_cmp++;
         if (got_cyc_q[0] - t0 != 3 + CPB / 2 + 9 * CPB) begin
            n_bad++;
            $display("FAIL single_latency: got %0d cycles, required %0d",
                     got_cyc_q[0] - t0, 3 + CPB / 2 + 9 * CPB);
         end
      end
      n_cmp++;
      if (data_out !== 8'hA9 || fe_cnt != 0) begin
         n_bad++;
         $display("FAIL single_hold: data_out=%02h frame_errs=%0d, required a9/0",
                  data_out, fe_cnt);
      end
      last_good = 8'hA9;
   endtask

   task automatic test_glitch();
      bit saw_busy = 1'b0;
      clear_obs();
      @(posedge CLOCK);
      #1 rx = 1'b0;
      repeat (5) @(posedge CLOCK);
      #1 rx = 1'b1;
      for (int i = 0; i < 3 * CPB; i++) begin
         @(negedge CLOCK);
         if (busy === 1'b1) saw_busy = 1'b1;
      end
      n_cmp++;
      if (!saw_busy) begin
         n_bad++;
         $display("FAIL glitch_detect: busy never rose, required start detection");
      end
      n_cmp++;
      if (got_q.size() != 0 || fe_cnt != 0 || busy !== 1'b0 || data_out !== last_good) begin
         n_bad++;
         $display("FAIL glitch_reject: valids=%0d fe=%0d busy=%b data_out=%02h, required 0/0/0/%02h",
                  got_q.size(), fe_cnt, busy, data_out, last_good);
      end
   endtask

   task automatic test_frame_err();
      int t0;
      logic [7:0] b;
      clear_obs();
      send_frame(8'h55, BIT_NOM, BIT_NOM, 1'b0, 1'b1, t0);
      #(3 * BIT_NOM);
      @(negedge CLOCK);
      n_cmp++;
      if (fe_cnt != 1 || got_q.size() != 0) begin
         n_bad++;
         $display("FAIL ferr_pulse: frame_errs=%0d valids=%0d, required 1/0", fe_cnt, got_q.size());
      end
      n_cmp++;
      if (data_out !== last_good || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL ferr_hold: data_out=%02h busy=%b, required %02h/1", data_out, busy, last_good);
      end
      rx = 1'b1;
      wait_cycles(5);
      @(negedge CLOCK);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL ferr_release: busy=%b, required 0", busy);
      end
      b = 8'($urandom);
      send_frame(b, BIT_NOM, BIT_NOM, 1'b1, 1'b0, t0);
      wait_cycles(4);
      n_cmp++;
      if (got_q.size() != 1 || data_out !== b || fe_cnt != 1) begin
         n_bad++;
         $display("FAIL ferr_recover: valids=%0d data_out=%02h fe=%0d, required 1/%02h/1",
                  got_q.size(), data_out, fe_cnt, b);
      end
      last_good = b;
   endtask

   // compare collected bytes with the intended stream
   task automatic test_stream(input string name, input int n, input int bit_t, input int stop_t);
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int t0;
      clear_obs();
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send_frame(b, bit_t, stop_t, 1'b1, (i == 0), t0);
      end
      wait_cycles(2 * CPB);
      n_cmp++;
      if (got_q.size() != exp_q.size() || fe_cnt != 0) begin
         n_bad++;
         $display("FAIL %s_count: valids=%0d frame_errs=%0d, required %0d/0",
                  name, got_q.size(), fe_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, got_q[i], exp_q[i]);
         end
      end
      if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
   endtask

   task automatic test_back_to_back();
      // stop bit cut to 3/4 so each start edge follows the stop center closely
      test_stream("b2b", 8, BIT_NOM, (BIT_NOM * 3) / 4);
   endtask

   task automatic test_baud_skew();
      test_stream("skew_slow", 128, BIT_SLOW, BIT_SLOW);
      test_stream("skew_fast", 128, BIT_FAST, BIT_FAST);
   endtask

   task automatic test_reset_mid();
      int t0;
      clear_obs();
      @(posedge CLOCK);
      #1 rx = 1'b0;
      #(BIT_NOM);
      rx = 1'b1;
      #(4 * BIT_NOM);
      RESET_N = 1'b0;
      @(negedge CLOCK);
      n_cmp++;
      if ({data_out, data_valid, frame_err, busy} !== '0) begin
         n_bad++;
         $display("FAIL midreset_vals: data_out=%02h dv=%b fe=%b busy=%b, required all 0",
                  data_out, data_valid, frame_err, busy);
      end
      wait_cycles(3);
      #1 RESET_N = 1'b1;
      #(5 * BIT_NOM);
      @(negedge CLOCK);
      n_cmp++;
      if (got_q.size() != 0 || fe_cnt != 0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_quiet: valids=%0d fe=%0d busy=%b, required 0/0/0",
                  got_q.size(), fe_cnt, busy);
      end
      send_frame(8'h3C, BIT_NOM, BIT_NOM, 1'b1, 1'b1, t0);
      wait_cycles(4);
      n_cmp++;
      if (got_q.size() != 1 || fe_cnt != 0) begin
         n_bad++;
         $display("FAIL midreset_count: valids=%0d fe=%0d, required 1/0", got_q.size(), fe_cnt);
      end else begin
         n_cmp++;
         if (got_q[0] !== 8'h3C) begin
            n_bad++;
            $display("FAIL midreset_byte: got %02h, required 3c", got_q[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_baud_skew();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
